// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/block widths, schedule FSM states and the
// rotate / small-sigma helpers used by both the message schedule and compression.
package sha256_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BLOCK_W        = 512;
    localparam int unsigned ROUNDS_DEFAULT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // n must stay in 1..31; every caller passes a constant
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned      n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word from the sliding window: W[t+16] = s1(W[t+14]) + W[t+9]
// + s0(W[t+1]) + W[t], modulo 2^32.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_next
);

    assign w_next = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts a 512-bit block, streams W0..W(ROUNDS-1)
// with round index. Optional `MSG_SCHED_ABORT_EN adds a synchronous abort input.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned IDX_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MSG_SCHED_ABORT_EN
    input  logic               abort,
`endif
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [IDX_W-1:0]   w_idx,
    output logic               w_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] window [0:15];
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] w_new;
    logic              abort_req;
    logic              load;
    logic              advance;
    logic              at_last;

`ifdef MSG_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign at_last = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        blk_ready  = 1'b0;
        w_valid    = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                // ready is withheld during abort so upstream never sees a dropped handshake
                blk_ready = !abort_req;
                load      = blk_valid && !abort_req;
                if (load) state_next = RUN;
            end
            RUN: begin
                w_valid = 1'b1;
                if (abort_req) begin
                    state_next = IDLE;
                end else if (w_ready) begin
                    advance = 1'b1;
                    if (at_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (load || abort_req) begin
            idx <= '0;
        end else if (advance) begin
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

    sha256_w_next u_w_next (
        .w0     (window[0]),
        .w1     (window[1]),
        .w9     (window[9]),
        .w14    (window[14]),
        .w_next (w_new)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 16; i++) window[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++)
                window[i] <= blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
        end else if (advance && !at_last) begin
            for (int unsigned i = 0; i < 15; i++) window[i] <= window[i+1];
            window[15] <= w_new;
        end
    end

    assign w_data = window[0];
    assign w_idx  = idx;
    assign w_last = (state == RUN) && at_last;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed self-checking bench for sha256_msg_sched; abort cases are exercised
// when built with MSG_SCHED_ABORT_EN.
module tb_sha256_msg_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;
`ifdef MSG_SCHED_ABORT_EN
    logic         abort;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_w [0:63];
    logic [31:0]  got_w [0:63];
    logic [511:0] blk_abc;
    logic [511:0] blk_two;

    always #5 clk = ~clk;

    sha256_msg_sched #(.ROUNDS(64), .IDX_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MSG_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Called at the negedge after the block was accepted; consumes words
    // first_n..stop_n-1 and returns at the negedge after the last handshake.
    task automatic stream(input bit stall, input int first_n, input int stop_n);
        int          n = first_n;
        int          cyc = 0;
        bit          stalled = 0;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        bit          rdy;
        while (n < stop_n && cyc < 400) begin
            if (stalled) begin
                check_eq("stall_data", w_data, pd);
                check_eq("stall_idx", {26'b0, w_idx}, {26'b0, pi});
            end
            rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            w_ready = rdy;
            check_eq("w_valid_run", {31'b0, w_valid}, 32'd1);
            check_eq("blk_ready_run", {31'b0, blk_ready}, 32'd0);
            check_eq("w_last", {31'b0, w_last}, (n == 63) ? 32'd1 : 32'd0);
            if (w_valid && rdy) begin
                check_eq("w_idx", {26'b0, w_idx}, 32'(n));
                check_eq("w_data", w_data, exp_w[n]);
                got_w[n] = w_data;
                n++;
                stalled = 0;
            end else begin
                stalled = w_valid;
                pd = w_data;
                pi = w_idx;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("handshakes", 32'(n), 32'(stop_n));
    endtask

    task automatic load_block(input logic [511:0] b);
        check_eq("blk_ready_idle", {31'b0, blk_ready}, 32'd1);
        blk_valid = 1'b1;
        blk_data  = b;
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        blk_abc = '0;
        blk_abc[511:480] = 32'h61626380;
        blk_abc[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++)
            blk_two[511-32*i -: 32] = (32'h01010101 * i) ^ 32'hDEADBEEF;

        rst = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        check_eq("rst_blk_ready", {31'b0, blk_ready}, 32'd1);
        check_eq("rst_w_valid", {31'b0, w_valid}, 32'd0);
        check_eq("rst_w_last", {31'b0, w_last}, 32'd0);
        check_eq("rst_w_idx", {26'b0, w_idx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // "abc" block, no backpressure
        build_model(blk_abc);
        load_block(blk_abc);
        stream(1'b0, 0, 64);
        check_eq("abc_W0", got_w[0], 32'h61626380);
        check_eq("abc_W15", got_w[15], 32'h00000018);
        check_eq("abc_W16", got_w[16], 32'h61626380);
        check_eq("abc_W17", got_w[17], 32'h000F0000);
        check_eq("abc_W63", got_w[63], 32'h12B1EDEB);
        check_eq("done_blk_ready", {31'b0, blk_ready}, 32'd1);
        check_eq("done_w_valid", {31'b0, w_valid}, 32'd0);

        // same block with random backpressure
        load_block(blk_abc);
        stream(1'b1, 0, 64);
        check_eq("stall_W63", got_w[63], 32'h12B1EDEB);
        w_ready = 1'b1;

        // blk_valid pulse with another block while running is ignored
        load_block(blk_abc);
        stream(1'b0, 0, 5);
        blk_valid = 1'b1;
        blk_data  = blk_two;
        stream(1'b0, 5, 6);
        blk_valid = 1'b0;
        stream(1'b0, 6, 64);

        // back-to-back with blk_valid held high
        blk_valid = 1'b1;
        blk_data  = blk_abc;
        @(negedge clk);
        stream(1'b0, 0, 64);
        blk_data = blk_two;
        check_eq("b2b_blk_ready", {31'b0, blk_ready}, 32'd1);
        build_model(blk_two);
        @(negedge clk);
        blk_valid = 1'b0;
        stream(1'b0, 0, 64);

        // asynchronous reset mid-block at idx 20
        load_block(blk_two);
        stream(1'b0, 0, 20);
        check_eq("pre_rst_idx", {26'b0, w_idx}, 32'd20);
        rst = 1'b0;
        #1;
        check_eq("arst_w_valid", {31'b0, w_valid}, 32'd0);
        check_eq("arst_blk_ready", {31'b0, blk_ready}, 32'd1);
        check_eq("arst_w_idx", {26'b0, w_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build_model(blk_abc);
        load_block(blk_abc);
        stream(1'b0, 0, 64);

`ifdef MSG_SCHED_ABORT_EN
        load_block(blk_abc);
        stream(1'b0, 0, 30);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_w_valid", {31'b0, w_valid}, 32'd0);
        check_eq("abort_blk_ready", {31'b0, blk_ready}, 32'd1);
        check_eq("abort_w_idx", {26'b0, w_idx}, 32'd0);
        abort     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = blk_abc;
        @(negedge clk);
        abort     = 1'b0;
        blk_valid = 1'b0;
        check_eq("abort_noload", {31'b0, w_valid}, 32'd0);
        load_block(blk_abc);
        stream(1'b0, 0, 64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
